// File: rtl/maze_query_arbiter.sv
// maze_query_arbiter: round-robin sharing of the maze legality ROM among sprite movers,
// with a tag pipe that routes each ROM result back to the mover that asked for it.
module maze_query_arbiter #(
    parameter int         N_REQ   = 4,
    parameter int         ROM_LAT = 2,
    parameter logic [9:0] H_MIN   = 10'd150,
    parameter logic [9:0] H_MAX   = 10'd630,
    parameter logic [9:0] V_MIN   = 10'd34,
    parameter logic [9:0] V_MAX   = 10'd514
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [10*N_REQ-1:0]   req_x,
    input  logic [10*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [3:0]            rsp_legal,
    output logic                  rom_valid,
    output logic [9:0]            rom_x,
    output logic [9:0]            rom_y,
    input  logic [3:0]            rom_legal,
    output logic                  busy
);
    localparam int             PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW:0]    NR   = (PW+1)'(N_REQ);
    localparam logic [PW-1:0]  LAST = PW'(N_REQ - 1);

    logic [PW-1:0]     ptr, win, idx;
    logic [PW:0]       sum;
    logic              found, in_win;
    logic [N_REQ-1:0]  elig, gmask, cmask, pending;
    logic [9:0]        sx, sy;
    logic [ROM_LAT:0]  tv, tb;
    logic [PW-1:0]     tw [ROM_LAT+1];

    always_comb begin
        elig  = req & ~pending;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            idx = PW'(sum >= NR ? sum - NR : sum);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        sx     = req_x[10*win +: 10];
        sy     = req_y[10*win +: 10];
        in_win = sx >= H_MIN && sx <= H_MAX && sy >= V_MIN && sy <= V_MAX;
        gmask  = found ? N_REQ'(1) << win : '0;
        cmask  = tv[ROM_LAT] ? N_REQ'(1) << tw[ROM_LAT] : '0;
    end

    assign busy = |pending;

    // Out-of-window queries still ride the tag pipe so every response has the same latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            rsp_valid <= '0;
            rsp_legal <= '0;
            rom_valid <= 1'b0;
            rom_x     <= '0;
            rom_y     <= '0;
            pending   <= '0;
            ptr       <= '0;
            tv        <= '0;
            tb        <= '0;
            for (int k = 0; k <= ROM_LAT; k++) tw[k] <= '0;
        end else begin
            grant     <= gmask;
            rsp_valid <= cmask;
            pending   <= (pending | gmask) & ~cmask;
            rom_valid <= found && in_win;
            if (found) ptr <= win == LAST ? '0 : win + 1'b1;
            if (found && in_win) begin
                rom_x <= sx;
                rom_y <= sy;
            end
            if (tv[ROM_LAT]) rsp_legal <= tb[ROM_LAT] ? 4'b0000 : rom_legal;
            tv    <= {tv[ROM_LAT-1:0], found};
            tb    <= {tb[ROM_LAT-1:0], !in_win};
            tw[0] <= win;
            for (int k = 1; k <= ROM_LAT; k++) tw[k] <= tw[k-1];
        end
    end
endmodule

// File: tb/tb_maze_query_arbiter.sv
// tb_maze_query_arbiter: cycle-by-cycle vector table plus directed round-robin and reset sequences,
// against a two-stage ROM model that returns x[5:2] (or 4'b1111 when not strobed).
module tb_maze_query_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] req_x, req_y;
    logic [3:0]  grant, rsp_valid, rsp_legal, rom_legal;
    logic        rom_valid, busy;
    logic [9:0]  rom_x, rom_y;
    logic [3:0]  s1, s2;
    int          total = 0, passed = 0;

    maze_query_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_legal(rsp_legal),
        .rom_valid(rom_valid), .rom_x(rom_x), .rom_y(rom_y),
        .rom_legal(rom_legal), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s1 <= rom_valid ? rom_x[5:2] : 4'b1111;
        s2 <= s1;
    end
    assign rom_legal = s2;

    typedef struct {
        logic [3:0]  req;
        logic [39:0] x, y;
        logic [3:0]  g;
        logic        rv;
        logic [9:0]  rx, ry;
        logic [3:0]  rsp, lg;
        logic        b;
    } vec_t;
    vec_t vt[$];

    localparam logic [39:0] P  = {10'd288, 10'd272, 10'd264, 10'd260};
    localparam logic [39:0] Y  = {10'd200, 10'd200, 10'd200, 10'd200};
    localparam logic [39:0] XS = {10'd288, 10'd272, 10'd264, 10'd360};
    localparam logic [39:0] YS = {10'd200, 10'd200, 10'd200, 10'd400};
    localparam logic [39:0] XB = {10'd288, 10'd272, 10'd100, 10'd300};
    localparam logic [39:0] YB = {10'd200, 10'd200, 10'd200, 10'd300};

    function automatic vec_t mk(logic [3:0] r, logic [39:0] x, logic [39:0] y, logic [3:0] g,
                                logic rv, logic [9:0] rx, logic [9:0] ry, logic [3:0] rsp,
                                logic [3:0] lg, logic b);
        vec_t v;
        v = '{r, x, y, g, rv, rx, ry, rsp, lg, b};
        return v;
    endfunction

    task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %h, expected %h", name, i, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (busy && n < 10) begin
            tick;
            n++;
        end
        chk(name, n, 64'(busy), 64'(0));
    endtask

    initial begin
        // pipelining: 0..3 back to back, responses in order
        vt.push_back(mk(4'b1111, P, Y, 4'b0001, 1'b1, 10'd260, 10'd200, 4'b0000, 4'b0000, 1'b1));
        vt.push_back(mk(4'b1110, P, Y, 4'b0010, 1'b1, 10'd264, 10'd200, 4'b0000, 4'b0000, 1'b1));
        vt.push_back(mk(4'b1100, P, Y, 4'b0100, 1'b1, 10'd272, 10'd200, 4'b0000, 4'b0000, 1'b1));
        vt.push_back(mk(4'b1000, P, Y, 4'b1000, 1'b1, 10'd288, 10'd200, 4'b0001, 4'b0001, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd288, 10'd200, 4'b0010, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd288, 10'd200, 4'b0100, 4'b0100, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd288, 10'd200, 4'b1000, 4'b1000, 1'b0));
        // single query x=360 y=400
        vt.push_back(mk(4'b0001, XS, YS, 4'b0001, 1'b1, 10'd360, 10'd400, 4'b0000, 4'b1000, 1'b1));
        vt.push_back(mk(4'b0000, XS, YS, 4'b0000, 1'b0, 10'd360, 10'd400, 4'b0000, 4'b1000, 1'b1));
        vt.push_back(mk(4'b0000, XS, YS, 4'b0000, 1'b0, 10'd360, 10'd400, 4'b0000, 4'b1000, 1'b1));
        vt.push_back(mk(4'b0000, XS, YS, 4'b0000, 1'b0, 10'd360, 10'd400, 4'b0001, 4'b1010, 1'b0));
        // bypass on 1 plus in-window on 0
        vt.push_back(mk(4'b0011, XB, YB, 4'b0010, 1'b0, 10'd360, 10'd400, 4'b0000, 4'b1010, 1'b1));
        vt.push_back(mk(4'b0001, XB, YB, 4'b0001, 1'b1, 10'd300, 10'd300, 4'b0000, 4'b1010, 1'b1));
        vt.push_back(mk(4'b0000, XB, YB, 4'b0000, 1'b0, 10'd300, 10'd300, 4'b0000, 4'b1010, 1'b1));
        vt.push_back(mk(4'b0000, XB, YB, 4'b0000, 1'b0, 10'd300, 10'd300, 4'b0010, 4'b0000, 1'b1));
        vt.push_back(mk(4'b0000, XB, YB, 4'b0000, 1'b0, 10'd300, 10'd300, 4'b0001, 4'b1011, 1'b0));
        // ptr to 2, then 3 beats 1
        vt.push_back(mk(4'b0010, P, Y, 4'b0010, 1'b1, 10'd264, 10'd200, 4'b0000, 4'b1011, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd264, 10'd200, 4'b0000, 4'b1011, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd264, 10'd200, 4'b0000, 4'b1011, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd264, 10'd200, 4'b0010, 4'b0010, 1'b0));
        vt.push_back(mk(4'b1010, P, Y, 4'b1000, 1'b1, 10'd288, 10'd200, 4'b0000, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0010, P, Y, 4'b0010, 1'b1, 10'd264, 10'd200, 4'b0000, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd264, 10'd200, 4'b0000, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd264, 10'd200, 4'b1000, 4'b1000, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd264, 10'd200, 4'b0010, 4'b0010, 1'b0));
        // req[2] and req[0] held: one outstanding each, regrant the cycle after the response
        vt.push_back(mk(4'b0101, P, Y, 4'b0100, 1'b1, 10'd272, 10'd200, 4'b0000, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0101, P, Y, 4'b0001, 1'b1, 10'd260, 10'd200, 4'b0000, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0101, P, Y, 4'b0000, 1'b0, 10'd260, 10'd200, 4'b0000, 4'b0010, 1'b1));
        vt.push_back(mk(4'b0101, P, Y, 4'b0000, 1'b0, 10'd260, 10'd200, 4'b0100, 4'b0100, 1'b1));
        vt.push_back(mk(4'b0101, P, Y, 4'b0100, 1'b1, 10'd272, 10'd200, 4'b0001, 4'b0001, 1'b1));
        vt.push_back(mk(4'b0101, P, Y, 4'b0001, 1'b1, 10'd260, 10'd200, 4'b0000, 4'b0001, 1'b1));
        vt.push_back(mk(4'b0101, P, Y, 4'b0000, 1'b0, 10'd260, 10'd200, 4'b0000, 4'b0001, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd260, 10'd200, 4'b0100, 4'b0100, 1'b1));
        vt.push_back(mk(4'b0000, P, Y, 4'b0000, 1'b0, 10'd260, 10'd200, 4'b0001, 4'b0001, 1'b0));

        rst = 1'b1;
        req = '0;
        req_x = P;
        req_y = Y;
        repeat (2) tick;
        chk("reset", 0, 64'({grant, rsp_valid, rsp_legal, rom_valid, rom_x, rom_y, busy}), 64'(0));
        rst = 1'b0;

        foreach (vt[i]) begin
            req = vt[i].req;
            req_x = vt[i].x;
            req_y = vt[i].y;
            tick;
            chk("vec", i, 64'({grant, rom_valid, rom_x, rom_y, rsp_valid, rsp_legal, busy}),
                64'({vt[i].g, vt[i].rv, vt[i].rx, vt[i].ry, vt[i].rsp, vt[i].lg, vt[i].b}));
        end

        // all four held high from ptr=1: steady rotation 1,2,3,0,...
        req = 4'b1111;
        req_x = P;
        req_y = Y;
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("rr_grant", k, 64'(grant), 64'(4'b0001 << ((1 + k) % 4)));
            if (k >= 3) chk("rr_rsp", k, 64'({rsp_valid, rsp_legal}), 64'({2{4'b0001 << ((k - 2) % 4)}}));
        end
        req = '0;
        drain("rr_drain");

        // park ptr at 0, then grant 0 and 2 so ptr sits at 3 when reset hits
        req = 4'b1000;
        tick;
        chk("pre_rst_g3", 0, 64'(grant), 64'(4'b1000));
        req = '0;
        drain("pre_rst_drain");
        req = 4'b0101;
        tick;
        chk("pre_rst_g0", 0, 64'(grant), 64'(4'b0001));
        tick;
        chk("pre_rst_g2", 0, 64'(grant), 64'(4'b0100));
        rst = 1'b1;
        req = '0;
        #1;
        chk("async_rst", 0, 64'({grant, rsp_valid, rom_valid, rom_x, rom_y, busy}), 64'(0));
        tick;
        rst = 1'b0;
        begin
            logic seen = 1'b0;
            repeat (6) begin
                tick;
                if (rsp_valid != 4'b0000 || busy) seen = 1'b1;
            end
            chk("rst_no_rsp", 0, 64'(seen), 64'(0));
        end
        req = 4'b1010;
        tick;
        chk("post_rst_g1", 0, 64'(grant), 64'(4'b0010));
        req = 4'b1000;
        tick;
        chk("post_rst_g3", 0, 64'(grant), 64'(4'b1000));
        req = '0;
        drain("final_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
